// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Handshake bundle between a field producer/word consumer and the RV32I
//   instruction encoder.
//
//   Input side : in_valid/in_ready plus decoded fields
//                (opcode, rd, rs1, rs2, funct3, funct7, imm).
//   Output side: out_valid/out_ready plus the encoded instruction, its word
//                address and the NOP-substitute error flag.
//
//   Modports:
//     master - the environment (drives fields, consumes words)
//     slave  - the encoder
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] addr;
    logic              err;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instruction, addr, err
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instruction, addr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs decoded fields into a 32-bit RV32I instruction word (R, I, LOAD,
//   STORE, BRANCH, JAL). Unsupported opcodes produce a NOP (addi x0,x0,0)
//   with err set. Each emitted word carries a running word address.
//
//   Optional feature macro: IMM_RANGE_CHECK_EN
//     defined   - immediates that do not fit their format (or are odd for
//                 BRANCH/JAL) are replaced by a NOP with err set
//     undefined - excess immediate bits are silently dropped
//
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     clear - synchronous address counter reset to BASE_ADDR
//     bus   - instr_encoder_if.slave (input fields, output word handshake)
//
//   Flow: IDLE (accept bundle) -> ENC (register word) -> OUT (hold until
//   consumed). Peak throughput one word per three cycles.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    instr_encoder_if.slave bus
);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              latch_en;

    // Latched field bundle (pure data, no reset needed)
    logic [6:0]  op_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  f3_q;
    logic [6:0]  f7_q;
    logic [31:0] imm_q;

    logic [31:0] enc_word;
    logic        enc_err;

    // True when v is representable as an n-bit two's-complement value
    function automatic logic sign_fits(input logic [31:0] v, input int n);
        logic signed [31:0] hi;
        hi = $signed(v) >>> (n - 1);
        return (hi == 32'sd0) || (hi == -32'sd1);
    endfunction

    always_comb begin
        enc_err  = 1'b0;
        enc_word = NOP_WORD;
        case (op_q)
            7'b0110011: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
            7'b0010011,
            7'b0000011: enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
            7'b0100011: enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q,
                                    imm_q[4:0], op_q};
            7'b1100011: enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                                    imm_q[4:1], imm_q[11], op_q};
            7'b1101111: enc_word = {imm_q[20], imm_q[10:1], imm_q[11],
                                    imm_q[19:12], rd_q, op_q};
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
`ifdef IMM_RANGE_CHECK_EN
        // Out-of-range immediates fall back to the NOP substitute
        case (op_q)
            7'b0010011, 7'b0000011, 7'b0100011:
                if (!sign_fits(imm_q, 12)) begin
                    enc_word = NOP_WORD;
                    enc_err  = 1'b1;
                end
            7'b1100011:
                if (!sign_fits(imm_q, 13) || imm_q[0]) begin
                    enc_word = NOP_WORD;
                    enc_err  = 1'b1;
                end
            7'b1101111:
                if (!sign_fits(imm_q, 21) || imm_q[0]) begin
                    enc_word = NOP_WORD;
                    enc_err  = 1'b1;
                end
            default: ;
        endcase
`endif
    end

`ifndef IMM_RANGE_CHECK_EN
    // Upper immediate bits only matter to the range check
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_q[31:21];
`endif

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        err_d    = err_q;
        addr_d   = addr_q;
        latch_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    latch_en = 1'b1;
                    state_d  = S_ENC;
                end
            end
            S_ENC: begin
                instr_d = enc_word;
                err_d   = enc_err;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // clear overrides a coincident output handshake
        if (clear) begin
            addr_d = BASE_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            op_q  <= bus.opcode;
            rd_q  <= bus.rd;
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
            f3_q  <= bus.funct3;
            f7_q  <= bus.funct7;
            imm_q <= bus.imm;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_OUT);
    assign bus.instruction = instr_q;
    assign bus.err         = err_q;
    assign bus.addr        = addr_q;
endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. Three instances share one stimulus:
//     dut_a - default parameters (ADDR_W=8, BASE_ADDR=0), fully checked
//     dut_b - ADDR_W=2, used for address wrap
//     dut_c - BASE_ADDR=8'h5A, used for reset/clear target value
// ---------------------------------------------------------------------------
module tb_instr_encoder;
    logic clk;
    logic rst_n;
    logic clear;

    int checks = 0;
    int errors = 0;

    instr_encoder_if #(.ADDR_W(8)) bus_a ();
    instr_encoder_if #(.ADDR_W(2)) bus_b ();
    instr_encoder_if #(.ADDR_W(8)) bus_c ();

    instr_encoder #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a.slave)
    );
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_b.slave)
    );
    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h5A)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_c.slave)
    );

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.opcode    = bus_a.opcode;
    assign bus_b.rd        = bus_a.rd;
    assign bus_b.rs1       = bus_a.rs1;
    assign bus_b.rs2       = bus_a.rs2;
    assign bus_b.funct3    = bus_a.funct3;
    assign bus_b.funct7    = bus_a.funct7;
    assign bus_b.imm       = bus_a.imm;
    assign bus_b.out_ready = bus_a.out_ready;
    assign bus_c.in_valid  = bus_a.in_valid;
    assign bus_c.opcode    = bus_a.opcode;
    assign bus_c.rd        = bus_a.rd;
    assign bus_c.rs1       = bus_a.rs1;
    assign bus_c.rs2       = bus_a.rs2;
    assign bus_c.funct3    = bus_a.funct3;
    assign bus_c.funct7    = bus_a.funct7;
    assign bus_c.imm       = bus_a.imm;
    assign bus_c.out_ready = bus_a.out_ready;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic [31:0] EXP_I2048 = 32'h0000_0013;
    localparam logic        ERR_I2048 = 1'b1;
    localparam logic [31:0] EXP_B5    = 32'h0000_0013;
    localparam logic        ERR_B5    = 1'b1;
    localparam logic [31:0] EXP_JP20  = 32'h0000_0013;
    localparam logic        ERR_JP20  = 1'b1;
`else
    localparam logic [31:0] EXP_I2048 = 32'h8000_0093;
    localparam logic        ERR_I2048 = 1'b0;
    localparam logic [31:0] EXP_B5    = 32'h0020_8263;
    localparam logic        ERR_B5    = 1'b0;
    localparam logic [31:0] EXP_JP20  = 32'h8000_00EF;
    localparam logic        ERR_JP20  = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd_v,
                              input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im);
        bus_a.opcode = op;
        bus_a.rd     = rd_v;
        bus_a.rs1    = rs1_v;
        bus_a.rs2    = rs2_v;
        bus_a.funct3 = f3;
        bus_a.funct7 = f7;
        bus_a.imm    = im;
    endtask

    // Handshake one bundle and walk to OUT, checking latency on the way
    task automatic issue(input logic [6:0] op, input logic [4:0] rd_v,
                         input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im);
        set_fields(op, rd_v, rs1_v, rs2_v, f3, f7, im);
        bus_a.in_valid = 1'b1;
        chk("in_ready_idle", {31'd0, bus_a.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        chk("enc_out_valid_low", {31'd0, bus_a.out_valid}, 32'd0);
        chk("enc_in_ready_low", {31'd0, bus_a.in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("lat2_out_valid", {31'd0, bus_a.out_valid}, 32'd1);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] instr,
                               input logic e, input logic [7:0] a);
        chk({tag, "_instr"}, bus_a.instruction, instr);
        chk({tag, "_err"}, {31'd0, bus_a.err}, {31'd0, e});
        chk({tag, "_addr"}, {24'd0, bus_a.addr}, {24'd0, a});
    endtask

    task automatic retire();
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        chk("retire_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("retire_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        clear           = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rst_instr", bus_a.instruction, 32'd0);
        chk("rst_err", {31'd0, bus_a.err}, 32'd0);
        chk("rst_addr", {24'd0, bus_a.addr}, 32'd0);
        chk("rst_addr_c", {24'd0, bus_c.addr}, 32'h5A);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x1, x0, 5
        issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_word("addi5", 32'h0050_0093, 1'b0, 8'd0);
        retire();

        // sw then beq from a cleared counter
        pulse_clear();
        issue(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_word("sw", 32'h0020_A423, 1'b0, 8'd0);
        retire();
        issue(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        expect_word("beq_m4", 32'hFE20_8EE3, 1'b0, 8'd1);
        retire();

        issue(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        expect_word("jal8", 32'h0080_00EF, 1'b0, 8'd2);
        retire();
        issue(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
        expect_word("sub", 32'h4031_00B3, 1'b0, 8'd3);
        retire();

        // Stall in OUT while a new bundle is offered and withdrawn
        issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        set_fields(7'b0110011, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            bus_a.in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            expect_word("stall", 32'h0050_0093, 1'b0, 8'd4);
            chk("stall_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, bus_a.out_valid}, 32'd1);
        end
        bus_a.in_valid = 1'b0;
        retire();
        chk("stall_addr_inc", {24'd0, bus_a.addr}, 32'd5);

        // Immediate boundaries and unsupported opcode
        issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_word("addi2048", EXP_I2048, ERR_I2048, 8'd5);
        retire();
        issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        expect_word("addi_m2048", 32'h8000_0093, 1'b0, 8'd6);
        retire();
        issue(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5);
        expect_word("beq_odd", EXP_B5, ERR_B5, 8'd7);
        retire();
        issue(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6);
        expect_word("beq6", 32'h0020_8363, 1'b0, 8'd8);
        retire();
        issue(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
        expect_word("jal_min", 32'h8000_00EF, 1'b0, 8'd9);
        retire();
        issue(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0);
        expect_word("bad_op", 32'h0000_0013, 1'b1, 8'd10);
        retire();
        issue(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        expect_word("jal_2p20", EXP_JP20, ERR_JP20, 8'd11);
        retire();

        // Address wrap on the 2-bit instance
        pulse_clear();
        chk("clear_addr_c", {24'd0, bus_c.addr}, 32'h5A);
        for (int i = 0; i < 5; i++) begin
            issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
            chk("wrap_addr_a", {24'd0, bus_a.addr}, i);
            chk("wrap_addr_b", {30'd0, bus_b.addr}, i % 4);
            retire();
        end

        // clear coincident with output handshake
        issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        clear           = 1'b1;
        bus_a.out_ready = 1'b1;
        #1;
        chk("clear_not_comb", {24'd0, bus_a.addr}, 32'd5);
        @(posedge clk); #1;
        clear           = 1'b0;
        bus_a.out_ready = 1'b0;
        chk("clear_hs_addr", {24'd0, bus_a.addr}, 32'd0);
        chk("clear_hs_addr_c", {24'd0, bus_c.addr}, 32'h5A);
        chk("clear_hs_idle", {31'd0, bus_a.in_ready}, 32'd1);

        // Reset during ENC
        issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        retire();
        set_fields(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_enc_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rst_enc_addr", {24'd0, bus_a.addr}, 32'd0);
        chk("rst_enc_addr_c", {24'd0, bus_c.addr}, 32'h5A);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_enc_no_stale", {31'd0, bus_a.out_valid}, 32'd0);
            chk("rst_enc_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        end

        // Reset during OUT
        issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        retire();
        issue(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        chk("pre_rst_out_addr", {24'd0, bus_a.addr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rst_out_addr", {24'd0, bus_a.addr}, 32'd0);
        chk("rst_out_instr", bus_a.instruction, 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_out_no_stale", {31'd0, bus_a.out_valid}, 32'd0);
            chk("rst_out_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        end

        // Normal operation resumes after reset
        issue(7'b0000011, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFFF);
        expect_word("lw_m1", 32'hFFF1_2203, 1'b0, 8'd0);
        retire();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
